id_stage: RTL and testbench

Instruction-decode stage of the 5-stage pipeline. Consumes the IF/ID register contents (instruction, PC+1), decodes the instruction and reads operands through external register-file ports. It also forwards results from EX/MEM/WB, resolves branches and jumps in ID and detects load-use hazards. It drives the fetch-stage control (PCsrc, targets, KILL, stalls) and produces the registered ID/EX pipeline register.

---
 rtl/id_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_id_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: operand fetch/forwarding, ID-resolved branches, load-use stall, ID/EX register.
// Optional `ID_PERF_CNT_EN adds saturating stall/kill counters.
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction_D,
    input  logic [31:0] NPC_D,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        ex_regwr,
    input  logic        mem_regwr,
    input  logic        wb_regwr,
    input  logic        ex_memrd,
    input  logic [31:0] ex_result,
    input  logic [31:0] mem_result,
    input  logic [31:0] wb_result,
    output logic [1:0]  PCsrc,
    output logic [31:0] PC_offset,
    output logic [31:0] PC_regRs,
    output logic        KILL,
    output logic        disable_PC,
    output logic        disable_IR,
    output logic [3:0]  idex_op,
    output logic        idex_alusrc,
    output logic        idex_memrd,
    output logic        idex_memwr,
    output logic        idex_regwr,
    output logic [4:0]  idex_rd,
    output logic [31:0] idex_A,
    output logic [31:0] idex_B,
    output logic [31:0] idex_imm,
    output logic [31:0] idex_sd
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] kill_cnt
`endif
);
    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_ANDI = 6'd5;
    localparam logic [5:0] OP_LW   = 6'd6;
    localparam logic [5:0] OP_SW   = 6'd7;
    localparam logic [5:0] OP_BEQ  = 6'd8;
    localparam logic [5:0] OP_BNE  = 6'd9;
    localparam logic [5:0] OP_J    = 6'd10;
    localparam logic [5:0] OP_JR   = 6'd11;

    logic [5:0]  w_op;
    logic [4:0]  w_rd, w_rs, w_rt;
    logic [31:0] w_sext;
    logic        w_rtype, w_valid, w_use1, w_use2;
    logic        w_alusrc, w_memrd, w_memwr, w_regwr;
    logic        w_beq, w_bne, w_j, w_jr;
    logic [3:0]  w_aluop;
    logic [31:0] w_src1, w_src2;
    logic        w_stall, w_taken, w_kill;

    logic [3:0]  r_op;
    logic        r_alusrc, r_memrd, r_memwr, r_regwr;
    logic [4:0]  r_rd;
    logic [31:0] r_A, r_B, r_imm, r_sd;

    assign w_op   = Instruction_D[31:26];
    assign w_rd   = Instruction_D[25:21];
    assign w_rs   = Instruction_D[20:16];
    assign w_rt   = Instruction_D[15:11];
    assign w_sext = {{16{Instruction_D[15]}}, Instruction_D[15:0]};

    always_comb begin
        w_rtype  = 1'b0;
        w_valid  = 1'b0;
        w_use1   = 1'b1;
        w_use2   = 1'b0;
        w_alusrc = 1'b0;
        w_memrd  = 1'b0;
        w_memwr  = 1'b0;
        w_regwr  = 1'b0;
        w_beq    = 1'b0;
        w_bne    = 1'b0;
        w_j      = 1'b0;
        w_jr     = 1'b0;
        w_aluop  = 4'd0;
        unique case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                w_rtype = 1'b1;
                w_valid = 1'b1;
                w_use2  = 1'b1;
                w_regwr = 1'b1;
                w_aluop = {2'b00, w_op[1:0]};
            end
            OP_ADDI, OP_ANDI: begin
                w_valid  = 1'b1;
                w_alusrc = 1'b1;
                w_regwr  = 1'b1;
                w_aluop  = (w_op == OP_ANDI) ? 4'd2 : 4'd0;
            end
            OP_LW: begin
                w_valid  = 1'b1;
                w_alusrc = 1'b1;
                w_memrd  = 1'b1;
                w_regwr  = 1'b1;
            end
            OP_SW: begin
                w_valid  = 1'b1;
                w_use2   = 1'b1;
                w_alusrc = 1'b1;
                w_memwr  = 1'b1;
            end
            OP_BEQ: begin
                w_use2 = 1'b1;
                w_beq  = 1'b1;
            end
            OP_BNE: begin
                w_use2 = 1'b1;
                w_bne  = 1'b1;
            end
            OP_J: begin
                w_use1 = 1'b0;
                w_j    = 1'b1;
            end
            OP_JR:   w_jr = 1'b1;
            default: w_valid = 1'b0;
        endcase
    end

    assign rs_addr = w_rs;
    assign rt_addr = w_rtype ? w_rt : w_rd;

    // A load in EX has no value yet, so it is never a forwarding source.
    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0)
            return 32'd0;
        else if (ex_regwr && !ex_memrd && ex_rd == a)
            return ex_result;
        else if (mem_regwr && mem_rd == a)
            return mem_result;
        else if (wb_regwr && wb_rd == a)
            return wb_result;
        else
            return rf;
    endfunction

    assign w_src1 = fwd(rs_addr, rs_data);
    assign w_src2 = fwd(rt_addr, rt_data);

    assign w_stall = ex_memrd && (ex_rd != 5'd0) &&
                     ((w_use1 && ex_rd == rs_addr) ||
                      (w_use2 && ex_rd == rt_addr));

    assign w_taken = (w_beq && (w_src1 == w_src2)) ||
                     (w_bne && (w_src1 != w_src2)) || w_j;
    assign w_kill  = !w_stall && (w_taken || w_jr);

    always_comb begin
        PCsrc = 2'b00;
        if (!w_stall && w_taken)
            PCsrc = 2'b01;
        else if (!w_stall && w_jr)
            PCsrc = 2'b10;
    end

    assign KILL       = w_kill;
    assign disable_PC = w_stall;
    assign disable_IR = w_stall;
    assign PC_offset  = NPC_D - 32'd1 + w_sext;
    assign PC_regRs   = w_src1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || w_stall || !w_valid) begin
            r_op     <= 4'd0;
            r_alusrc <= 1'b0;
            r_memrd  <= 1'b0;
            r_memwr  <= 1'b0;
            r_regwr  <= 1'b0;
            r_rd     <= 5'd0;
            r_A      <= 32'd0;
            r_B      <= 32'd0;
            r_imm    <= 32'd0;
            r_sd     <= 32'd0;
        end else begin
            r_op     <= w_aluop;
            r_alusrc <= w_alusrc;
            r_memrd  <= w_memrd;
            r_memwr  <= w_memwr;
            r_regwr  <= w_regwr && (w_rd != 5'd0);
            r_rd     <= w_rd;
            r_A      <= w_src1;
            r_B      <= w_alusrc ? w_sext : w_src2;
            r_imm    <= w_sext;
            r_sd     <= w_memwr ? w_src2 : 32'd0;
        end
    end

    assign idex_op     = r_op;
    assign idex_alusrc = r_alusrc;
    assign idex_memrd  = r_memrd;
    assign idex_memwr  = r_memwr;
    assign idex_regwr  = r_regwr;
    assign idex_rd     = r_rd;
    assign idex_A      = r_A;
    assign idex_B      = r_B;
    assign idex_imm    = r_imm;
    assign idex_sd     = r_sd;

`ifdef ID_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_kill_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
            r_kill_cnt  <= 32'd0;
        end else begin
            if (w_stall && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_kill && r_kill_cnt != 32'hFFFF_FFFF)
                r_kill_cnt <= r_kill_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign kill_cnt  = r_kill_cnt;
`endif
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, reset/counter sequences, random vs. reference model.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction_D, NPC_D;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_regwr, mem_regwr, wb_regwr, ex_memrd;
    logic [31:0] ex_result, mem_result, wb_result;
    logic [1:0]  PCsrc;
    logic [31:0] PC_offset, PC_regRs;
    logic        KILL, disable_PC, disable_IR;
    logic [3:0]  idex_op;
    logic        idex_alusrc, idex_memrd, idex_memwr, idex_regwr;
    logic [4:0]  idex_rd;
    logic [31:0] idex_A, idex_B, idex_imm, idex_sd;
`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt, kill_cnt;
`endif

    logic [31:0] rf [32];
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rs_data = rf[rs_addr];
    assign rt_data = rf[rt_addr];

    id_stage dut (
        .clk(clk), .reset(reset),
        .Instruction_D(Instruction_D), .NPC_D(NPC_D),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwr(ex_regwr), .mem_regwr(mem_regwr), .wb_regwr(wb_regwr),
        .ex_memrd(ex_memrd),
        .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
        .PCsrc(PCsrc), .PC_offset(PC_offset), .PC_regRs(PC_regRs),
        .KILL(KILL), .disable_PC(disable_PC), .disable_IR(disable_IR),
        .idex_op(idex_op), .idex_alusrc(idex_alusrc),
        .idex_memrd(idex_memrd), .idex_memwr(idex_memwr),
        .idex_regwr(idex_regwr), .idex_rd(idex_rd),
        .idex_A(idex_A), .idex_B(idex_B),
        .idex_imm(idex_imm), .idex_sd(idex_sd)
`ifdef ID_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0]  rsa, rta;
        logic [1:0]  pcsrc;
        logic        kill, stall;
        logic [31:0] pcoff, pcrs;
        logic [3:0]  op;
        logic        alusrc, memrd, memwr, regwr;
        logic [4:0]  rd;
        logic [31:0] A, B, imm, sd;
    } exp_t;

    typedef struct packed {
        logic [31:0] ins, npc, rsd, rtd;
        logic [4:0]  exrd;
        logic        exw, exm;
        logic [31:0] exr;
        logic [4:0]  memrd;
        logic        memw;
        logic [31:0] memr;
        logic [4:0]  wbrd;
        logic        wbw;
        logic [31:0] wbr;
        logic [1:0]  e_pcsrc;
        logic        e_kill, e_stall;
        logic [31:0] e_tgt, e_A;
        logic        e_regwr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] R(input int op, input int d, input int s, input int t);
        logic [31:0] x;
        x = 32'd0;
        x[31:26] = 6'(op);
        x[25:21] = 5'(d);
        x[20:16] = 5'(s);
        x[15:11] = 5'(t);
        return x;
    endfunction

    function automatic logic [31:0] I(input int op, input int d, input int s, input logic [15:0] imm);
        logic [31:0] x;
        x = R(op, d, s, 0);
        x[15:0] = imm;
        return x;
    endfunction

    // Value a reader of register a sees: newest producer in the pipe, else the file.
    function automatic logic [31:0] mval(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (ex_regwr && !ex_memrd && ex_rd == a) return ex_result;
        if (mem_regwr && mem_rd == a) return mem_result;
        if (wb_regwr && wb_rd == a) return wb_result;
        return rf[a];
    endfunction

    function automatic exp_t model();
        exp_t e;
        int op;
        logic [4:0] d, s, t;
        logic [31:0] imm, a, b;
        logic rty, u1, u2;
        e = '0;
        op = int'(Instruction_D[31:26]);
        d = Instruction_D[25:21];
        s = Instruction_D[20:16];
        t = Instruction_D[15:11];
        imm = {{16{Instruction_D[15]}}, Instruction_D[15:0]};
        rty = (op <= 3);
        e.rsa = s;
        e.rta = rty ? t : d;
        u1 = (op != 10);
        u2 = rty || op == 7 || op == 8 || op == 9;
        a = mval(e.rsa);
        b = mval(e.rta);
        e.stall = ex_memrd && ex_rd != 0 &&
                  ((u1 && ex_rd == e.rsa) || (u2 && ex_rd == e.rta));
        e.pcoff = NPC_D + imm - 32'd1;
        e.pcrs = a;
        if (!e.stall) begin
            if ((op == 8 && a == b) || (op == 9 && a != b) || op == 10) begin
                e.pcsrc = 2'b01;
                e.kill = 1'b1;
            end else if (op == 11) begin
                e.pcsrc = 2'b10;
                e.kill = 1'b1;
            end
        end
        if (!e.stall && op <= 7) begin
            case (op)
                1: e.op = 4'd1;
                2, 5: e.op = 4'd2;
                3: e.op = 4'd3;
                default: e.op = 4'd0;
            endcase
            e.alusrc = (op >= 4);
            e.memrd = (op == 6);
            e.memwr = (op == 7);
            e.regwr = (op <= 6) && (d != 0);
            e.rd = d;
            e.A = a;
            e.B = (op >= 4) ? imm : b;
            e.imm = imm;
            e.sd = (op == 7) ? b : 32'd0;
        end
        return e;
    endfunction

    task automatic clr_fwd();
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_regwr = 0; mem_regwr = 0; wb_regwr = 0; ex_memrd = 0;
        ex_result = 0; mem_result = 0; wb_result = 0;
    endtask

    task automatic step_model(input string tag);
        exp_t e;
        @(negedge clk);
        e = model();
        chk({tag, " rs_addr"}, 32'(rs_addr), 32'(e.rsa));
        chk({tag, " rt_addr"}, 32'(rt_addr), 32'(e.rta));
        chk({tag, " PCsrc"}, 32'(PCsrc), 32'(e.pcsrc));
        chk({tag, " KILL"}, 32'(KILL), 32'(e.kill));
        chk({tag, " disable_PC"}, 32'(disable_PC), 32'(e.stall));
        chk({tag, " disable_IR"}, 32'(disable_IR), 32'(e.stall));
        chk({tag, " PC_offset"}, PC_offset, e.pcoff);
        chk({tag, " PC_regRs"}, PC_regRs, e.pcrs);
        @(posedge clk);
        #1;
        chk({tag, " idex_op"}, 32'(idex_op), 32'(e.op));
        chk({tag, " idex_alusrc"}, 32'(idex_alusrc), 32'(e.alusrc));
        chk({tag, " idex_memrd"}, 32'(idex_memrd), 32'(e.memrd));
        chk({tag, " idex_memwr"}, 32'(idex_memwr), 32'(e.memwr));
        chk({tag, " idex_regwr"}, 32'(idex_regwr), 32'(e.regwr));
        chk({tag, " idex_rd"}, 32'(idex_rd), 32'(e.rd));
        chk({tag, " idex_A"}, idex_A, e.A);
        chk({tag, " idex_B"}, idex_B, e.B);
        chk({tag, " idex_imm"}, idex_imm, e.imm);
        chk({tag, " idex_sd"}, idex_sd, e.sd);
    endtask

    function automatic vec_t mkv(
        input logic [31:0] ins, npc, rsd, rtd,
        input int exrd, input logic exw, exm, input logic [31:0] exr,
        input int memrd, input logic memw, input logic [31:0] memr,
        input int wbrd, input logic wbw, input logic [31:0] wbr,
        input logic [1:0] pcsrc, input logic kill, stall,
        input logic [31:0] tgt, a, input logic regwr);
        vec_t v;
        v.ins = ins; v.npc = npc; v.rsd = rsd; v.rtd = rtd;
        v.exrd = 5'(exrd); v.exw = exw; v.exm = exm; v.exr = exr;
        v.memrd = 5'(memrd); v.memw = memw; v.memr = memr;
        v.wbrd = 5'(wbrd); v.wbw = wbw; v.wbr = wbr;
        v.e_pcsrc = pcsrc; v.e_kill = kill; v.e_stall = stall;
        v.e_tgt = tgt; v.e_A = a; v.e_regwr = regwr;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        logic rty;
        Instruction_D = v.ins;
        NPC_D = v.npc;
        rty = (v.ins[31:26] <= 6'd3);
        rf[rty ? v.ins[15:11] : v.ins[25:21]] = v.rtd;
        rf[v.ins[20:16]] = v.rsd;
        ex_rd = v.exrd; ex_regwr = v.exw; ex_memrd = v.exm; ex_result = v.exr;
        mem_rd = v.memrd; mem_regwr = v.memw; mem_result = v.memr;
        wb_rd = v.wbrd; wb_regwr = v.wbw; wb_result = v.wbr;
    endtask

    vec_t vt [16];

    initial begin
        reset = 1'b1;
        Instruction_D = 0;
        NPC_D = 0;
        clr_fwd();
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst idex_regwr", 32'(idex_regwr), 0);
        chk("rst idex_A", idex_A, 0);
        chk("rst idex_rd", 32'(idex_rd), 0);
        @(negedge clk);
        reset = 1'b0;

        // asynchronous reset in mid-stream
        rf[1] = 32'd11; rf[2] = 32'd22;
        Instruction_D = R(0, 3, 1, 2);
        @(posedge clk);
        #1;
        chk("pre-rst idex_regwr", 32'(idex_regwr), 1);
        chk("pre-rst idex_A", idex_A, 32'd11);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst idex_regwr", 32'(idex_regwr), 0);
        chk("async rst idex_A", idex_A, 0);
        chk("async rst idex_B", idex_B, 0);
        chk("async rst idex_rd", 32'(idex_rd), 0);
        @(negedge clk);
        reset = 1'b0;
        Instruction_D = 32'd0;
        #1;
        chk("nop PCsrc", 32'(PCsrc), 0);
        @(posedge clk);
        #1;
        chk("nop idex_regwr", 32'(idex_regwr), 0);

`ifdef ID_PERF_CNT_EN
        chk("cnt stall reset", stall_cnt, 0);
        chk("cnt kill reset", kill_cnt, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clr_fwd();
            if (i == 0 || i == 2 || i == 4) begin
                Instruction_D = R(0, 5, 4, 1);
                ex_rd = 4; ex_regwr = 1; ex_memrd = 1;
            end else if (i == 1 || i == 3) begin
                Instruction_D = I(10, 0, 0, 16'd3);
            end else begin
                Instruction_D = R(0, 5, 4, 1);
            end
        end
        @(negedge clk);
        Instruction_D = 32'd0;
        clr_fwd();
        chk("cnt stall", stall_cnt, 32'd3);
        chk("cnt kill", kill_cnt, 32'd2);
`endif

        // directed vectors: ins npc rsd rtd | ex | mem | wb | pcsrc kill stall tgt A regwr
        vt[0]  = mkv(R(0,3,1,2), 0, 11, 22, 1,1,0,5, 1,1,9, 0,0,0, 0,0,0, 0, 5, 1);
        vt[1]  = mkv(R(0,3,0,2), 0, 11, 22, 0,1,0,5, 0,0,0, 0,0,0, 0,0,0, 0, 0, 1);
        vt[2]  = mkv(R(0,5,4,1), 0, 1, 2, 4,1,1,55, 0,0,0, 0,0,0, 0,0,1, 0, 0, 0);
        vt[3]  = mkv(R(0,5,4,1), 0, 1, 2, 0,0,0,0, 4,1,7, 0,0,0, 0,0,0, 0, 7, 1);
        vt[4]  = mkv(I(8,2,3,16'hFFFC), 20, 42, 42, 0,0,0,0, 0,0,0, 0,0,0, 1,1,0, 15, 0, 0);
        vt[5]  = mkv(I(8,2,3,16'hFFFC), 20, 1, 2, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0, 0);
        vt[6]  = mkv(I(11,0,6,16'h0), 0, 0, 0, 0,0,0,0, 0,0,0, 6,1,100, 2,1,0, 100, 0, 0);
        vt[7]  = mkv(I(10,0,3,16'h5), 10, 0, 0, 3,1,1,0, 0,0,0, 0,0,0, 1,1,0, 14, 0, 0);
        vt[8]  = mkv(I(8,2,3,16'h4), 20, 5, 5, 2,1,1,0, 0,0,0, 0,0,0, 0,0,1, 0, 0, 0);
        vt[9]  = mkv(I(9,2,3,16'h8), 100, 5, 5, 0,0,0,0, 2,1,6, 0,0,0, 1,1,0, 107, 0, 0);
        vt[10] = mkv(R(15,3,1,2), 0, 11, 22, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0, 0);
        vt[11] = mkv(32'd0, 0, 0, 0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 0, 0);
        vt[12] = mkv(R(0,5,0,1), 0, 3, 4, 0,1,1,0, 0,0,0, 0,0,0, 0,0,0, 0, 0, 1);
        vt[13] = mkv(R(1,7,1,2), 0, 11, 22, 0,0,0,0, 1,1,9, 1,1,3, 0,0,0, 0, 9, 1);
        vt[14] = mkv(R(0,7,1,2), 0, 11, 22, 1,0,0,77, 0,0,0, 1,1,3, 0,0,0, 0, 3, 1);
        vt[15] = mkv(I(4,1,2,16'hFFFF), 0, 10, 0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0, 10, 1);

        for (int i = 0; i < 16; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply_vec(vt[i]);
            @(negedge clk);
            chk({tag, " PCsrc"}, 32'(PCsrc), 32'(vt[i].e_pcsrc));
            chk({tag, " KILL"}, 32'(KILL), 32'(vt[i].e_kill));
            chk({tag, " disable_PC"}, 32'(disable_PC), 32'(vt[i].e_stall));
            chk({tag, " disable_IR"}, 32'(disable_IR), 32'(vt[i].e_stall));
            if (vt[i].e_pcsrc == 2'b01) chk({tag, " PC_offset"}, PC_offset, vt[i].e_tgt);
            if (vt[i].e_pcsrc == 2'b10) chk({tag, " PC_regRs"}, PC_regRs, vt[i].e_tgt);
            @(posedge clk);
            #1;
            chk({tag, " idex_A"}, idex_A, vt[i].e_A);
            chk({tag, " idex_regwr"}, 32'(idex_regwr), 32'(vt[i].e_regwr));
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[31:26] = 6'($urandom_range(0, 15));
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            ins[15:11] = 5'($urandom_range(0, 7));
            Instruction_D = ins;
            NPC_D = $urandom;
            ex_rd = 5'($urandom_range(0, 7));
            mem_rd = 5'($urandom_range(0, 7));
            wb_rd = 5'($urandom_range(0, 7));
            ex_regwr = 1'($urandom);
            mem_regwr = 1'($urandom);
            wb_regwr = 1'($urandom);
            ex_memrd = ($urandom_range(0, 3) == 0);
            ex_result = $urandom;
            mem_result = $urandom;
            wb_result = $urandom;
            if (n % 4 == 0) begin
                rf[$urandom_range(1, 7)] = rf[$urandom_range(1, 7)];
            end
            step_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
